// File: rtl/fetch_prefetch.sv
// Instruction prefetch unit: issues sequential reads ahead of decode and queues the
// returned words with their PCs; a redirect flushes the queue and drops in-flight reads.
module fetch_prefetch #(
   parameter int XLEN = 32,
   parameter int DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic                     mem_req_o,
   output logic [XLEN-1:0]          mem_addr_o,
   input  logic                     mem_gnt_i,
   input  logic                     mem_rvalid_i,
   input  logic [31:0]              mem_rdata_i,
   input  logic                     redirect_i,
   input  logic [XLEN-1:0]          redirect_pc_i,
   output logic                     instr_valid_o,
   output logic [31:0]              instr_o,
   output logic [XLEN-1:0]          instr_pc_o,
   input  logic                     instr_ready_i,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] DepthW = (CW+1)'(DEPTH);

   logic [XLEN-1:0] fetchPc_q, fetchPc_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [AW-1:0]   head_q, head_d;
   logic [AW-1:0]   tail_q, tail_d;
   logic [AW-1:0]   tagWr_q, tagWr_d;
   logic [AW-1:0]   tagRd_q, tagRd_d;

   logic [31:0]     dataMem_q [DEPTH];
   logic [XLEN-1:0] pcMem_q   [DEPTH];
   logic [XLEN-1:0] tagMem_q  [DEPTH];

   logic [CW:0]     inFlight;
   logic            grant;
   logic            rspValid;
   logic            push;
   logic            pop;

   // Counting outstanding reads against free slots guarantees every response has room.
   assign inFlight      = {1'b0, count_q} + {1'b0, outstanding_q};
   assign mem_req_o     = !reset && !redirect_i && (inFlight < DepthW);
   assign mem_addr_o    = fetchPc_q;
   assign grant         = mem_req_o && mem_gnt_i;
   assign rspValid      = mem_rvalid_i && (outstanding_q != '0);
   assign push          = rspValid && (drop_q == '0) && !redirect_i;
   assign pop           = instr_valid_o && instr_ready_i && !redirect_i;

   assign instr_valid_o = (count_q != '0);
   assign instr_o       = instr_valid_o ? dataMem_q[head_q] : '0;
   assign instr_pc_o    = instr_valid_o ? pcMem_q[head_q] : '0;
   assign count_o       = count_q;

   // The tag queue always holds exactly one PC per outstanding read, so dropped
   // responses retire their own stale tags and no explicit clear is needed on redirect.
   always_comb begin
      fetchPc_d     = fetchPc_q;
      count_d       = count_q;
      outstanding_d = outstanding_q + CW'(grant) - CW'(rspValid);
      drop_d        = drop_q;
      head_d        = head_q + AW'(pop);
      tail_d        = tail_q + AW'(push);
      tagWr_d       = tagWr_q + AW'(grant);
      tagRd_d       = tagRd_q + AW'(rspValid);

      if (redirect_i) begin
         fetchPc_d = redirect_pc_i & ~XLEN'(3);
         count_d   = '0;
         head_d    = '0;
         tail_d    = '0;
         drop_d    = outstanding_q - CW'(rspValid);
      end else begin
         if (grant) begin
            fetchPc_d = fetchPc_q + XLEN'(4);
         end
         if (rspValid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetchPc_q     <= RESET_PC;
         count_q       <= '0;
         outstanding_q <= '0;
         drop_q        <= '0;
         head_q        <= '0;
         tail_q        <= '0;
         tagWr_q       <= '0;
         tagRd_q       <= '0;
      end else begin
         fetchPc_q     <= fetchPc_d;
         count_q       <= count_d;
         outstanding_q <= outstanding_d;
         drop_q        <= drop_d;
         head_q        <= head_d;
         tail_q        <= tail_d;
         tagWr_q       <= tagWr_d;
         tagRd_q       <= tagRd_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         dataMem_q[tail_q] <= mem_rdata_i;
         pcMem_q[tail_q]   <= tagMem_q[tagRd_q];
      end
      if (grant) begin
         tagMem_q[tagWr_q] <= fetchPc_q;
      end
   end

   rvalidWithoutRequest: assert property (@(posedge clk) disable iff (reset)
      mem_rvalid_i |-> (outstanding_q != '0));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Randomised and directed bench for fetch_prefetch: a reference model tracks
// fetch PCs per redirect epoch and a scoreboard checks every consumed instruction.
module tb_fetch_prefetch;

   localparam int XLEN = 32;
   localparam int DEPTH = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] instr_pc_o;
   logic        instr_ready_i;
   logic [2:0]  count_o;

   fetch_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
      .instr_ready_i(instr_ready_i), .count_o(count_o)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] pc;
      int          epoch;
   } pend_t;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } exp_t;

   pend_t       pending[$];
   exp_t        expQ[$];
   int          checks = 0;
   int          failures = 0;
   int          modelCount = 0;
   logic [31:0] modelPc = RESET_PC;
   int          epoch = 0;
   int          popCount = 0;
   bit          armFirst = 0;
   logic [31:0] firstPc = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents are a fixed scramble of the address, so every word identifies its PC.
   function automatic logic [31:0] memWord(input logic [31:0] a);
      return {a[7:0], a[31:8]} ^ 32'hC0DE_1234;
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Monitor: every consumed instruction must match the oldest expected entry.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && instr_valid_o && instr_ready_i && !redirect_i) begin
         popCount++;
         if (armFirst) begin
            firstPc  = instr_pc_o;
            armFirst = 0;
         end
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL pop with empty scoreboard: got pc %0h expected none", instr_pc_o);
         end else begin
            e = expQ.pop_front();
            checkOutput("instr_pc_o", 64'(instr_pc_o), 64'(e.pc));
            checkOutput("instr_o", 64'(instr_o), 64'(e.data));
         end
      end
   end

   // Reference model: requests follow a linear PC stream per epoch; a redirect starts
   // a new epoch and responses belonging to older epochs are never delivered.
   always begin
      pend_t p;
      pend_t n;
      exp_t  x;
      bit    expReq;
      @(negedge clk);
      #2;
      if (reset) begin
         pending.delete();
         expQ.delete();
         modelCount = 0;
         modelPc    = RESET_PC;
         epoch++;
      end else begin
         expReq = !redirect_i && ((modelCount + pending.size()) < DEPTH);
         checkOutput("mem_req_o", 64'(mem_req_o), 64'(expReq));
         checkOutput("count_o", 64'(count_o), 64'(modelCount));
         checkOutput("instr_valid_o", 64'(instr_valid_o), 64'(modelCount != 0));
         if (modelCount != 0 && instr_ready_i && !redirect_i) modelCount--;
         if (mem_rvalid_i && pending.size() > 0) begin
            p = pending.pop_front();
            if (!redirect_i && p.epoch == epoch) begin
               x.pc   = p.pc;
               x.data = memWord(p.pc);
               expQ.push_back(x);
               modelCount++;
            end
         end
         if (expReq && mem_gnt_i) begin
            checkOutput("mem_addr_o", 64'(mem_addr_o), 64'(modelPc));
            n.addr  = mem_addr_o;
            n.pc    = modelPc;
            n.epoch = epoch;
            pending.push_back(n);
            modelPc = modelPc + 32'd4;
         end
         if (redirect_i) begin
            modelCount = 0;
            expQ.delete();
            modelPc = redirect_pc_i & ~32'h3;
            epoch++;
         end
      end
   end

   task automatic driveCycle(input int gntP, input int rvalidP, input int readyP, input int redirP);
      mem_gnt_i     = ($urandom_range(99) < gntP);
      instr_ready_i = ($urandom_range(99) < readyP);
      if (pending.size() > 0 && $urandom_range(99) < rvalidP) begin
         mem_rvalid_i = 1'b1;
         mem_rdata_i  = memWord(pending[0].addr);
      end else begin
         mem_rvalid_i = 1'b0;
         mem_rdata_i  = $urandom;
      end
      redirect_i    = ($urandom_range(99) < redirP);
      redirect_pc_i = $urandom;
   endtask

   task automatic applyStimulus(input int n, input int gntP, input int rvalidP, input int readyP, input int redirP);
      repeat (n) begin
         @(posedge clk);
         #1;
         driveCycle(gntP, rvalidP, readyP, redirP);
      end
   endtask

   task automatic redirectTo(input logic [31:0] pc, input bit withRvalid, input bit withReady);
      @(posedge clk);
      #1;
      driveCycle(100, withRvalid ? 100 : 0, withReady ? 100 : 0, 0);
      redirect_i    = 1'b1;
      redirect_pc_i = pc;
   endtask

   task automatic settle();
      @(negedge clk);
      #3;
   endtask

   initial begin
      int p0;
      bit done;
      logic [31:0] wrapAddr [4];
      wrapAddr[0] = 32'hFFFF_FFF4;
      wrapAddr[1] = 32'hFFFF_FFF8;
      wrapAddr[2] = 32'hFFFF_FFFC;
      wrapAddr[3] = 32'h0000_0000;

      reset = 1'b1;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
      redirect_i = 0; redirect_pc_i = '0; instr_ready_i = 0;
      #2;
      checkOutput("reset mem_req_o", 64'(mem_req_o), 64'(0));
      checkOutput("reset instr_valid_o", 64'(instr_valid_o), 64'(0));
      checkOutput("reset count_o", 64'(count_o), 64'(0));
      checkOutput("reset instr_o", 64'(instr_o), 64'(0));
      checkOutput("reset instr_pc_o", 64'(instr_pc_o), 64'(0));
      checkOutput("reset mem_addr_o", 64'(mem_addr_o), 64'(RESET_PC));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Streaming at one instruction per cycle.
      armFirst = 1;
      applyStimulus(10, 100, 100, 100, 0);
      settle();
      checkOutput("first pc after reset", 64'(firstPc), 64'(RESET_PC));
      p0 = popCount;
      applyStimulus(20, 100, 100, 100, 0);
      settle();
      checkOutput("throughput over 20 cycles", 64'(popCount - p0), 64'(20));

      // Back-pressure fills the queue and stops requests.
      applyStimulus(10, 100, 100, 0, 0);
      settle();
      checkOutput("count_o when full", 64'(count_o), 64'(DEPTH));
      checkOutput("mem_req_o when full", 64'(mem_req_o), 64'(0));
      applyStimulus(1, 100, 100, 100, 0);
      applyStimulus(6, 100, 100, 0, 0);
      settle();
      checkOutput("count_o after single pop", 64'(count_o), 64'(DEPTH));

      // Redirect with three reads in flight.
      redirectTo(32'h0000_0040, 0, 0);
      applyStimulus(3, 100, 0, 100, 0);
      redirectTo(32'h0000_0100, 0, 1);
      armFirst = 1;
      applyStimulus(15, 100, 100, 100, 0);
      settle();
      checkOutput("first pc after redirect 0x100", 64'(firstPc), 64'(32'h100));

      // Redirect coinciding with a response and a pop at count 2.
      redirectTo(32'h0000_0300, 0, 0);
      done = 0;
      for (int i = 0; i < 30 && !done; i++) begin
         @(posedge clk);
         #1;
         if (count_o == 3'd2 && pending.size() > 0) begin
            driveCycle(100, 100, 100, 0);
            redirect_i    = 1'b1;
            redirect_pc_i = 32'h0000_0200;
            done = 1;
         end else begin
            driveCycle(100, 100, 0, 0);
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("[TB] FAIL count_o never reached 2: got %0d expected 2", count_o);
      end
      applyStimulus(1, 100, 100, 100, 0);
      settle();
      checkOutput("count_o after redirect+pop", 64'(count_o), 64'(0));
      armFirst = 1;
      applyStimulus(12, 100, 100, 100, 0);
      settle();
      checkOutput("first pc after redirect 0x200", 64'(firstPc), 64'(32'h200));

      // Address wrap at the top of the address space.
      redirectTo(32'hFFFF_FFF6, 0, 1);
      armFirst = 1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1, 100, 100, 100, 0);
         settle();
         checkOutput("wrap mem_addr_o", 64'(mem_addr_o), 64'(wrapAddr[i]));
      end
      applyStimulus(6, 100, 100, 100, 0);
      settle();
      checkOutput("first pc after wrap redirect", 64'(firstPc), 64'(32'hFFFF_FFF4));

      // Random traffic with occasional redirects.
      applyStimulus(600, 70, 60, 60, 3);

      // Asynchronous reset with a full queue.
      redirectTo(32'h0000_0500, 0, 0);
      applyStimulus(12, 100, 100, 0, 0);
      settle();
      checkOutput("count_o full before reset", 64'(count_o), 64'(DEPTH));
      @(posedge clk);
      #3;
      reset = 1'b1;
      mem_gnt_i = 0; mem_rvalid_i = 0; redirect_i = 0; instr_ready_i = 0;
      #1;
      checkOutput("async reset mem_req_o", 64'(mem_req_o), 64'(0));
      checkOutput("async reset instr_valid_o", 64'(instr_valid_o), 64'(0));
      checkOutput("async reset count_o", 64'(count_o), 64'(0));
      checkOutput("async reset instr_o", 64'(instr_o), 64'(0));
      checkOutput("async reset instr_pc_o", 64'(instr_pc_o), 64'(0));
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      settle();
      checkOutput("mem_addr_o after reset", 64'(mem_addr_o), 64'(RESET_PC));
      checkOutput("mem_req_o after reset", 64'(mem_req_o), 64'(1));
      armFirst = 1;
      applyStimulus(10, 100, 100, 100, 0);
      settle();
      checkOutput("first pc after async reset", 64'(firstPc), 64'(RESET_PC));

      applyStimulus(2, 0, 100, 100, 0);
      settle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/fetch_prefetch.md
Name: fetch_prefetch

Overview:
Parametrised instruction-prefetch unit, successor to the single-word fetch stage. It issues sequential instruction reads on the shared memory port ahead of demand and buffers the returned words, with their PCs, in a DEPTH-entry FIFO. Decode drains the FIFO through a valid/ready handshake. A redirect from control (branch/jump/trap) flushes the queue and discards any reads still in flight.

Parameters:
XLEN, 32, address/PC width
DEPTH, 4, FIFO entries; power of two, >= 2; also the maximum number of outstanding reads
RESET_PC, 32'h0000_0000, first fetch address after reset (XLEN bits, low 2 bits zero)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
mem_req_o  out  1  read request to memory port
mem_addr_o  out  XLEN  word-aligned read address
mem_gnt_i  in  1  memory accepted request this cycle (ignored when mem_req_o=0)
mem_rvalid_i  in  1  read data returned this cycle; responses in order
mem_rdata_i  in  32  returned instruction word
redirect_i  in  1  flush and restart fetch
redirect_pc_i  in  XLEN  new fetch PC; bits [1:0] ignored and forced to 0
instr_valid_o  out  1  FIFO head valid
instr_o  out  32  head instruction
instr_pc_o  out  XLEN  head PC
instr_ready_i  in  1  decode consumes head when high with instr_valid_o
count_o  out  $clog2(DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - fetch_pc=RESET_PC; FIFO empty; outstanding=0; drop=0.
  - mem_req_o=0, instr_valid_o=0, count_o=0; instr_o and instr_pc_o = 0.
- Request issue:
  - mem_req_o = !reset && !redirect_i && (count + outstanding < DEPTH). This is combinational from registers plus redirect_i.
  - mem_addr_o = fetch_pc (registered).
  - On mem_req_o && mem_gnt_i: fetch_pc += 4 (mod 2^XLEN, so 0xFFFF_FFFC wraps to 0); outstanding++.
  - Each accepted request records its PC in an in-order PC tag queue of DEPTH entries.
- Response:
  - On mem_rvalid_i: outstanding--.
  - If drop>0, the word is discarded and drop--.
  - Otherwise {mem_rdata_i, tagged PC} is written to the FIFO tail.
  - rvalid with outstanding==0 is a protocol error; assert in simulation, ignore in RTL.
- Output:
  - instr_valid_o = (count!=0); head fields are driven from registered storage.
  - A word written on cycle N is visible at the head on cycle N+1; there is no bypass.
  - Pop occurs on instr_valid_o && instr_ready_i.
  - Push and pop in the same cycle leave count unchanged, including at full and at count=1.
- Flow control:
  - The occupancy-plus-outstanding limit guarantees every response has a slot; the FIFO never overflows.
  - Steady state with instr_ready_i=1 and single-cycle grant/response sustains 1 instr/cycle.
- Redirect (redirect_i=1 in cycle N):
  - FIFO emptied, so instr_valid_o=0 in cycle N+1.
  - fetch_pc={redirect_pc_i[XLEN-1:2],2'b00}.
  - drop = outstanding remaining after this cycle's rvalid, i.e. outstanding - rvalid. Any rvalid in cycle N is also discarded.
  - PC tag queue cleared of dropped entries.
  - Pop in cycle N has no effect beyond the flush; redirect wins over push and pop.
  - First new request is issued in cycle N+1 if the space rule permits. Space counts outstanding, so requests resume as drop drains.
- Back-to-back redirects:
  - Each later redirect recomputes drop from the current outstanding count; the last one wins.
- Counter widths:
  - outstanding and drop are $clog2(DEPTH)+1 bits; neither can exceed DEPTH.

Test Plan:
- Reset release, gnt=1, rvalid one cycle after gnt, ready=1 -> mem_addr_o 0,4,8,... each cycle; instr_pc_o 0,4,8 with matching data; sustained 1/cycle after fill latency.
- ready=0, DEPTH=4 -> exactly 4 requests granted, mem_req_o drops, count_o=4; ready=1 for one cycle -> one pop and one new request; no word lost or reordered.
- 3 reads outstanding, redirect to 0x100 -> next 3 rvalids discarded; first valid output is instr_pc_o=0x100 with data for address 0x100.
- Redirect same cycle as rvalid and pop at count=2 -> count_o=0 next cycle, that response dropped, drop=outstanding-1.
- Redirect to 0xFFFF_FFF6 -> mem_addr_o 0xFFFF_FFF4, then 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert reset mid-burst with FIFO full -> all outputs 0 immediately (asynchronous); after release the first request is to RESET_PC and stale rvalids are not accepted.
